// File: rtl/data_mem_responder.sv
// Data-side responder for the single-cycle RISC-V core: byte-addressable RAM plus
// a 16-byte I/O window (LEDs, cycle counter, store counter). Reads are combinational.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] IO_BASE     = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic [7:0]  led_out,
    output logic [31:0] cycle_count,
    output logic        misalign_err
);
    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [7:0]    r_led;
    logic [31:0]   r_cycle_count;
    logic [31:0]   r_store_count;
    logic          r_misalign_err;

    logic [AW-1:0] w_idx;
    logic          w_in_ram;
    logic          w_in_io;
    logic          w_misalign;
    logic [3:0]    w_be;
    logic          w_wr_ok;
    logic [31:0]   w_sel_word;
    logic          w_unused_f3;

    // Funct3[2] only distinguishes signed/unsigned loads, which the CPU handles.
    assign w_unused_f3 = Funct3[2];

    assign w_idx    = Mem_WrAddr[AW+1:2];
    assign w_in_ram = (Mem_WrAddr < RAM_BYTES);
    assign w_in_io  = (Mem_WrAddr[31:4] == IO_BASE[31:4]);
    assign w_wr_ok  = MemWrite && !w_misalign;

    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        case (Funct3[1:0])
            2'b00: begin
                w_misalign = 1'b0;
                w_be       = 4'b0001 << Mem_WrAddr[1:0];
            end
            2'b01: begin
                w_misalign = Mem_WrAddr[0];
                w_be       = 4'b0011 << {Mem_WrAddr[1], 1'b0};
            end
            2'b10: begin
                w_misalign = |Mem_WrAddr[1:0];
                w_be       = 4'b1111;
            end
            default: begin
                w_misalign = 1'b1;
                w_be       = 4'b0000;
            end
        endcase
    end

    always_comb begin
        w_sel_word = 32'h0;
        if (w_in_ram) begin
            w_sel_word = r_mem[w_idx];
        end else if (w_in_io) begin
            case (Mem_WrAddr[3:2])
                2'd0:    w_sel_word = {24'h0, r_led};
                2'd1:    w_sel_word = r_cycle_count;
                2'd2:    w_sel_word = r_store_count;
                default: w_sel_word = 32'h0;
            endcase
        end
    end

    // Right-justify the addressed byte/half; the CPU does the extension.
    assign ReadData = w_sel_word >> {Mem_WrAddr[1:0], 3'b000};

    // RAM has no reset so it can map onto block memory; writes are gated off during reset.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_ok && w_in_ram) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= Mem_WrData[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led          <= 8'h0;
            r_cycle_count  <= 32'h0;
            r_store_count  <= 32'h0;
            r_misalign_err <= 1'b0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (MemWrite) begin
                if (w_misalign) begin
                    r_misalign_err <= 1'b1;
                end else if (w_in_ram) begin
                    r_store_count <= r_store_count + 32'd1;
                end else if (w_in_io) begin
                    case (Mem_WrAddr[3:2])
                        2'd0:    r_led         <= Mem_WrData[7:0];
                        2'd1:    r_cycle_count <= 32'h0;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign led_out      = r_led;
    assign cycle_count  = r_cycle_count;
    assign misalign_err = r_misalign_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a byte-array reference model.
module tb_data_mem_responder;
    localparam logic [31:0] IO = 32'h0000_1000;
    localparam int RAMB = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'd0;
    logic [31:0] Mem_WrAddr = 32'h0;
    logic [31:0] Mem_WrData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  led_out;
    logic [31:0] cycle_count;
    logic        misalign_err;

    data_mem_responder #(.DEPTH_WORDS(64), .IO_BASE(IO)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Funct3(Funct3),
        .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData), .ReadData(ReadData),
        .led_out(led_out), .cycle_count(cycle_count), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: memory as a flat byte array, registers as plain variables.
    logic [7:0]  m_mem [RAMB];
    logic [7:0]  m_led;
    logic [31:0] m_cyc, m_stc;
    logic        m_err;
    bit          model_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        int base;
        w = 32'h0;
        if (a < RAMB) begin
            base = int'(a) / 4 * 4;
            w = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
        end else if (a >= IO && a <= IO + 15) begin
            case ((a - IO) / 4)
                0: w = {24'h0, m_led};
                1: w = m_cyc;
                2: w = m_stc;
                default: w = 32'h0;
            endcase
        end
        return w >> (8 * (a % 4));
    endfunction

    task automatic m_step(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int width;
        bit bad_align, clr;
        width = 1 << f3[1:0];
        bad_align = (f3[1:0] == 2'b11) || (a % width != 0);
        clr = 1'b0;
        if (we) begin
            if (bad_align) m_err = 1'b1;
            else if (a < RAMB) begin
                for (int i = 0; i < width; i++)
                    m_mem[int'(a) + i] = d[8 * ((int'(a) + i) % 4) +: 8];
                m_stc = m_stc + 1;
            end else if (a >= IO && a <= IO + 15) begin
                if ((a - IO) / 4 == 0) m_led = d[7:0];
                if ((a - IO) / 4 == 1) clr = 1'b1;
            end
        end
        m_cyc = clr ? 32'h0 : m_cyc + 1;
    endtask

    task automatic m_reset();
        m_led = 8'h0; m_cyc = 32'h0; m_stc = 32'h0; m_err = 1'b0;
    endtask

    task automatic do_cycle(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        MemWrite = we; Funct3 = f3; Mem_WrAddr = a; Mem_WrData = d;
        #1;
        rd = ReadData;
        if (model_on) begin
            chk("model_rd", ReadData, m_read(a));
            chk("model_led", {24'h0, led_out}, {24'h0, m_led});
            chk("model_cyc", cycle_count, m_cyc);
            chk("model_err", {31'h0, misalign_err}, {31'h0, m_err});
        end
        @(posedge clk);
        m_step(we, f3, a, d);
    endtask

    // Reset pulse between edges; checks the cleared outputs while reset is high.
    task automatic rst_pulse();
        @(negedge clk);
        MemWrite = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_led", {24'h0, led_out}, 32'h0);
        chk("rst_cyc", cycle_count, 32'h0);
        chk("rst_err", {31'h0, misalign_err}, 32'h0);
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        m_cyc = m_cyc + 1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int sel;

        for (int i = 0; i < RAMB; i++) m_mem[i] = 8'h0;
        m_reset();

        // Vectors: pre-edge ReadData / misalign_err as each op is presented.
        tbl.push_back('{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 3'd2, IO + 8,   32'h0,        32'h1,        1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h20,   32'h0,        32'h0,        1'b0});
        tbl.push_back('{1'b1, 3'd0, 32'h22,   32'hABABABAB, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h20,   32'h0,        32'h00AB0000, 1'b0});
        tbl.push_back('{1'b0, 3'd0, 32'h22,   32'h0,        32'h000000AB, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h24,   32'hCAFEF00D, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 3'd1, 32'h26,   32'h12341234, 32'h0000CAFE, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h24,   32'h0,        32'h1234F00D, 1'b0});
        tbl.push_back('{1'b0, 3'd1, 32'h26,   32'h0,        32'h00001234, 1'b0});
        tbl.push_back('{1'b1, 3'd2, 32'h13,   32'h11111111, 32'h000000DE, 1'b0});
        tbl.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b1});
        tbl.push_back('{1'b1, 3'd1, 32'h21,   32'hFFFFFFFF, 32'h0000AB00, 1'b1});
        tbl.push_back('{1'b0, 3'd2, 32'h20,   32'h0,        32'h00AB0000, 1'b1});
        tbl.push_back('{1'b0, 3'd2, IO + 8,   32'h0,        32'h5,        1'b1});
        tbl.push_back('{1'b1, 3'd0, IO,       32'h5A5A5A5A, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 3'd2, IO,       32'h0,        32'h5A,       1'b1});
        tbl.push_back('{1'b0, 3'd4, IO,       32'h0,        32'h5A,       1'b1});
        tbl.push_back('{1'b1, 3'd2, 32'h800,  32'h12345678, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 3'd2, 32'h800,  32'h0,        32'h0,        1'b1});
        tbl.push_back('{1'b1, 3'd2, IO + 8,   32'hFFFFFFFF, 32'h5,        1'b1});
        tbl.push_back('{1'b0, 3'd2, IO + 8,   32'h0,        32'h5,        1'b1});
        tbl.push_back('{1'b0, 3'd2, IO + 12,  32'h0,        32'h0,        1'b1});

        // Power-on reset, then zero the RAM so the model knows every byte.
        repeat (2) @(posedge clk);
        rst_pulse();
        for (int w = 0; w < RAMB / 4; w++) do_cycle(1'b1, 3'd2, 32'(w * 4), 32'h0, rd);
        rst_pulse();
        model_on = 1'b1;

        foreach (tbl[i]) begin
            do_cycle(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].data, rd);
            chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'h0, misalign_err}, {31'h0, tbl[i].exp_err});
        end
        @(negedge clk);
        MemWrite = 1'b0;
        #1;
        chk("led_port", {24'h0, led_out}, 32'h5A);
        @(posedge clk);
        m_step(1'b0, 3'd0, 32'h0, 32'h0);

        // Reset raised mid-cycle with a store pending: clears at once, store discarded.
        @(negedge clk);
        MemWrite = 1'b1; Funct3 = 3'd2; Mem_WrAddr = 32'h10; Mem_WrData = 32'h0BADF00D;
        #2;
        reset = 1'b1;
        #1;
        chk("async_led", {24'h0, led_out}, 32'h0);
        chk("async_cyc", cycle_count, 32'h0);
        chk("async_err", {31'h0, misalign_err}, 32'h0);
        @(posedge clk);
        #1;
        chk("async_hold_cyc", cycle_count, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        MemWrite = 1'b0;
        m_reset();
        @(posedge clk);
        m_cyc = m_cyc + 1;
        do_cycle(1'b0, 3'd2, 32'h10, 32'h0, rd);
        chk("rst_write_dropped", rd, 32'hDEADBEEF);
        do_cycle(1'b0, 3'd2, IO + 8, 32'h0, rd);
        chk("stc_after_rst", rd, 32'h0);

        // Cycle counter clear via I/O store, then counting resumes from 0.
        do_cycle(1'b1, 3'd2, IO + 4, 32'hFFFFFFFF, rd);
        do_cycle(1'b0, 3'd2, IO + 4, 32'h0, rd);
        chk("clr_cyc0", rd, 32'h0);
        do_cycle(1'b0, 3'd2, IO + 4, 32'h0, rd);
        chk("clr_cyc1", rd, 32'h1);
        do_cycle(1'b0, 3'd2, IO + 4, 32'h0, rd);
        chk("clr_cyc2", rd, 32'h2);

        // Wrap: preload the counter to all-ones, next edge rolls to 0.
        @(negedge clk);
        MemWrite = 1'b0;
        force dut.r_cycle_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle_count;
        #1;
        chk("wrap_pre", cycle_count, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("wrap_post", cycle_count, 32'h0);
        m_cyc = 32'h0;

        // Randomized traffic against the model, with periodic resets to clear the sticky flag.
        for (int n = 0; n < 600; n++) begin
            if (n % 75 == 74) rst_pulse();
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = 32'($urandom_range(0, RAMB - 1));
            else if (sel < 8) a = IO + 32'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 3))
                    0: a = 32'h800;
                    1: a = 32'h100;
                    2: a = IO + 16;
                    default: a = 32'hFFFF_FFFC;
                endcase
            end
            do_cycle(1'($urandom_range(0, 1)),
                     {1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2))},
                     a, $urandom, rd);
        end

        @(negedge clk);
        MemWrite = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the single-cycle RISC-V datapath's load/store interface. It answers the CPU's Mem_WrAddr/Mem_WrData/ReadData bus with a byte-addressable data RAM and a small memory-mapped I/O window: an LED register, a free-running cycle counter and a store counter. Reads are combinational so the single-cycle CPU completes loads in one cycle. Writes commit on the clock edge with byte-lane enables derived from funct3. A sticky flag records misaligned accesses.

Parameters:
DEPTH_WORDS, 64, number of 32-bit RAM words (power of 2); RAM occupies byte addresses [0, 4*DEPTH_WORDS).
IO_BASE, 32'h0000_1000, base byte address of the 16-byte I/O window (16-byte aligned, above the RAM).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
MemWrite  input  1  store strobe from the CPU control unit.
Funct3  input  3  Instr[14:12]; only [1:0] select access width (00 byte, 01 half, 10 word, 11 illegal).
Mem_WrAddr  input  32  byte address (the ALU result).
Mem_WrData  input  32  store data, already lane-replicated by the CPU (byte copied 4x, half copied 2x).
ReadData  output  32  load data, right-justified: the addressed byte or half sits in the low bits; the CPU sign/zero-extends it.
led_out  output  8  LED register.
cycle_count  output  32  free-running cycle counter value.
misalign_err  output  1  sticky misaligned-access flag.

Behaviour:
- Reset is asynchronous and active-high: led_out=0, cycle_count=0, store_count=0, misalign_err=0. RAM contents are not reset; reading an unwritten word returns an undefined value.
- Address decode:
  - RAM: addr < 4*DEPTH_WORDS; word index = addr[log2(DEPTH_WORDS)+1:2].
  - I/O: IO_BASE <= addr <= IO_BASE+15; offset = addr[3:0].
  - Anything else is unmapped.
- Read path (combinational, zero latency):
  - sel_word = the addressed RAM word, or the I/O register at offset {addr[3:2],2'b00}.
  - ReadData = sel_word >> (8*addr[1:0]), zero-filled.
  - Unmapped addresses read 0.
  - I/O map: 0x0 = {24'b0, led_out}; 0x4 = cycle_count; 0x8 = store_count; 0xC reads 0.
- Alignment: an access is misaligned if it is a half with addr[0]=1, a word with addr[1:0]!=0, or Funct3[1:0]=11.
- Write path, when MemWrite=1 at the rising edge:
  - Misaligned, any region: no state change except misalign_err <= 1. The flag holds until reset.
  - RAM, aligned: byte enables are byte 1<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. Each enabled lane k takes Mem_WrData[8k+7:8k]. store_count increments by 1.
  - I/O offset 0x0: led_out <= Mem_WrData[7:0] for any aligned width.
  - I/O offset 0x4: cycle_count <= 0. The clear overrides that cycle's increment, so cycle_count reads 0 on the next cycle.
  - I/O offsets 0x8 and 0xC, and unmapped addresses: write ignored, no error.
  - I/O writes do not increment store_count.
- cycle_count increments by 1 every rising edge while reset is low, and wraps 32'hFFFF_FFFF -> 0. store_count also wraps at 2^32.
- MemWrite=0: no write, no error, regardless of address or Funct3. Reads are always active.
- Reset asserted mid-cycle clears the registers immediately. A write coincident with reset is discarded.
- Write-then-read of the same address: the new data is visible combinationally after the edge. There is no read-during-write bypass within a cycle; the old data is shown until the edge.

Test Plan:
- Word write/read: SW 0xDEADBEEF to addr 0x10 -> LW at 0x10 gives ReadData 0xDEADBEEF; store_count=1.
- Byte lanes: SW 0 to 0x20, then SB with data 0xABABABAB at 0x22 -> LW 0x20 = 0x00AB0000; LB at 0x22 gives ReadData 0x000000AB.
- Half lanes: SH with data 0x12341234 at 0x26 -> LW at 0x24 = 0x1234xxxx (low half unchanged); LH at 0x26 gives ReadData 0x00001234.
- Misalign: SW at 0x13 -> RAM word 0x10 unchanged, misalign_err=1 and held; store_count unchanged. SH at 0x21 behaves the same.
- I/O: SB 0x5A to IO_BASE -> led_out=0x5A. SW to IO_BASE+4 -> cycle_count reads 0, then 1, 2, ... on following cycles. LW IO_BASE+8 returns the number of successful RAM stores.
- Reset/wrap: force cycle_count to 0xFFFFFFFF -> next edge gives 0. Assert reset asynchronously mid-cycle -> all outputs 0 before the next edge. Unmapped addr 0x800 reads 0 and ignores writes.
